// File: rtl/apu_cluster_package.sv
// Shared APU cluster constants.
// FP_WIDTH: operand/result width used by the floating-point units and their issuers.
package apu_cluster_package;
  localparam int FP_WIDTH = 32;
endpackage

// File: rtl/fp_addsub_issuer.sv
// Purpose: issues add/sub ops to a pipelined FP unit with a tag, reorders returned
//   results in a tag-indexed buffer and hands them back to the core in issue order.
// Latency: issue is combinational (unit_en_o same cycle as the request fire); a unit
//   result reaches resp_* one cycle later, or the same cycle for the head tag when
//   FP_ADDSUB_ISSUER_BYPASS_EN is defined.
// Backpressure: req_ready_o drops when the unit is busy or all tags are in flight;
//   resp_valid_o holds with stable data until resp_ready_i.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   req_*                         core request (valid/ready, sub, opa, opb, rnd)
//   resp_*                        core response (valid/ready, res, status)
//   unit_en_o .. unit_rnd_o       operation sent to the FP unit, tagged
//   unit_ready_i                  FP unit can take an op this cycle
//   unit_valid_i .. unit_status_i tagged result coming back from the FP unit
//   err_o                         sticky: result arrived for a tag not in flight
// Optional macro: FP_ADDSUB_ISSUER_BYPASS_EN (same-cycle head-result bypass).
module fp_addsub_issuer
  import apu_cluster_package::*;
#(
  parameter int TAG_WIDTH  = 2,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_sub_i,
  input  logic [FP_WIDTH-1:0]   req_opa_i,
  input  logic [FP_WIDTH-1:0]   req_opb_i,
  input  logic [RND_WIDTH-1:0]  req_rnd_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [FP_WIDTH-1:0]   resp_res_o,
  output logic [STAT_WIDTH-1:0] resp_status_o,
  output logic                  unit_en_o,
  output logic                  unit_subsel_o,
  output logic [FP_WIDTH-1:0]   unit_opa_o,
  output logic [FP_WIDTH-1:0]   unit_opb_o,
  output logic [TAG_WIDTH-1:0]  unit_tag_o,
  output logic [RND_WIDTH-1:0]  unit_rnd_o,
  input  logic                  unit_ready_i,
  input  logic                  unit_valid_i,
  input  logic [TAG_WIDTH-1:0]  unit_tag_i,
  input  logic [FP_WIDTH-1:0]   unit_res_i,
  input  logic [STAT_WIDTH-1:0] unit_status_i,
  output logic                  err_o
);

  localparam int                DEPTH   = 1 << TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] DEPTH_C = (TAG_WIDTH+1)'(DEPTH);

  logic [TAG_WIDTH-1:0]  wr_ptr;
  logic [TAG_WIDTH-1:0]  rd_ptr;
  logic [TAG_WIDTH:0]    count;
  logic [DEPTH-1:0]      rob_vld;
  logic [FP_WIDTH-1:0]   rob_res    [DEPTH];
  logic [STAT_WIDTH-1:0] rob_status [DEPTH];
  logic                  err;

  logic                  fire;
  logic                  retire;
  logic                  outstanding;
  logic                  byp;
  logic                  rob_write;
  logic [TAG_WIDTH-1:0]  tag_offset;
  logic                  head_vld;

  // ---------------------------------------------------------------- issue side
  // count is TAG_WIDTH+1 bits so "all tags in flight" is distinguishable from empty.
  assign req_ready_o = unit_ready_i && (count < DEPTH_C);
  assign fire        = req_valid_i && req_ready_o;

  assign unit_en_o     = fire;
  assign unit_subsel_o = fire ? req_sub_i : 1'b0;
  assign unit_opa_o    = fire ? req_opa_i : '0;
  assign unit_opb_o    = fire ? req_opb_i : '0;
  assign unit_rnd_o    = fire ? req_rnd_i : '0;
  assign unit_tag_o    = wr_ptr;

  // ---------------------------------------------------------------- return side
  // A tag is in flight when its distance from the head (mod DEPTH) is below count.
  // When every tag is in flight any distance qualifies, which the compare covers.
  // A tag whose result already landed is not in flight a second time.
  assign tag_offset  = unit_tag_i - rd_ptr;
  assign outstanding = (count != '0) && ({1'b0, tag_offset} < count) && !rob_vld[unit_tag_i];

  assign head_vld = rob_vld[rd_ptr];

`ifdef FP_ADDSUB_ISSUER_BYPASS_EN
  // The head's own result can go straight to the core; it only lands in the
  // buffer if the core does not take it this cycle.
  assign byp          = unit_valid_i && outstanding && (unit_tag_i == rd_ptr);
  assign resp_valid_o = head_vld || byp;
  assign resp_res_o    = byp      ? unit_res_i
                       : head_vld ? rob_res[rd_ptr]    : '0;
  assign resp_status_o = byp      ? unit_status_i
                       : head_vld ? rob_status[rd_ptr] : '0;
`else
  assign byp          = 1'b0;
  assign resp_valid_o = head_vld;
  assign resp_res_o    = head_vld ? rob_res[rd_ptr]    : '0;
  assign resp_status_o = head_vld ? rob_status[rd_ptr] : '0;
`endif

  assign retire    = resp_valid_o && resp_ready_i;
  assign rob_write = unit_valid_i && outstanding && !(byp && retire);
  assign err_o     = err;

  // ---------------------------------------------------------------- control state
  // A written entry is never the retiring head in the same cycle (write needs the
  // valid bit clear, retire from the buffer needs it set), so the two bit updates
  // below never collide.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rob_vld <= '0;
      err     <= 1'b0;
    end else begin
      if (fire)   wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;

      case ({fire, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (rob_write)                  rob_vld[unit_tag_i] <= 1'b1;
      if (retire && head_vld)         rob_vld[rd_ptr]     <= 1'b0;
      if (unit_valid_i && !outstanding) err              <= 1'b1;
    end
  end

  // Payload storage needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk_i) begin
    if (rob_write) begin
      rob_res[unit_tag_i]    <= unit_res_i;
      rob_status[unit_tag_i] <= unit_status_i;
    end
  end

endmodule

// File: tb/tb_fp_addsub_issuer.sv
module tb_fp_addsub_issuer;
  import apu_cluster_package::*;

`ifdef FP_ADDSUB_ISSUER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_sub;
  logic [31:0] req_opa, req_opb;
  logic [2:0]  req_rnd;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_res;
  logic [7:0]  resp_status;
  logic        unit_en, unit_subsel;
  logic [31:0] unit_opa, unit_opb;
  logic [1:0]  unit_tag_o;
  logic [2:0]  unit_rnd;
  logic        unit_ready, unit_valid;
  logic [1:0]  unit_tag;
  logic [31:0] unit_res;
  logic [7:0]  unit_status;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_addsub_issuer #(.TAG_WIDTH(2), .RND_WIDTH(3), .STAT_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_sub_i(req_sub),
    .req_opa_i(req_opa), .req_opb_i(req_opb), .req_rnd_i(req_rnd),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_res_o(resp_res), .resp_status_o(resp_status),
    .unit_en_o(unit_en), .unit_subsel_o(unit_subsel),
    .unit_opa_o(unit_opa), .unit_opb_o(unit_opb),
    .unit_tag_o(unit_tag_o), .unit_rnd_o(unit_rnd),
    .unit_ready_i(unit_ready), .unit_valid_i(unit_valid), .unit_tag_i(unit_tag),
    .unit_res_i(unit_res), .unit_status_i(unit_status), .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; unit_valid = 1'b0; resp_ready = 1'b0;
    unit_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Issue one op, checking what reaches the unit in the same cycle.
  task automatic issue(input logic [31:0] opa, input logic [1:0] exp_tag);
    req_valid = 1'b1; req_opa = opa; req_opb = opa ^ 32'h5a5a_0f0f;
    req_sub = opa[0]; req_rnd = opa[3:1];
    #1;
    chk("issue_en",  {31'd0, unit_en}, 32'd1);
    chk("issue_tag", {30'd0, unit_tag_o}, {30'd0, exp_tag});
    chk("issue_opa", unit_opa, opa);
    chk("issue_sub", {31'd0, unit_subsel}, {31'd0, opa[0]});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ret(input logic [1:0] tag, input logic [31:0] res, input logic [7:0] st);
    unit_valid = 1'b1; unit_tag = tag; unit_res = res; unit_status = st;
    tick();
    unit_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  tag;
    logic [31:0] res;
    logic [7:0]  st;
    bit          done;
  } ent_t;

  ent_t q[$];
  int   pend[$];

  initial begin
    logic [31:0] exp_res [3];
    int   pick;
    int   n_iss;
    bit   exp_ready, exp_en, exp_rv;

    req_sub = 0; req_opa = 0; req_opb = 0; req_rnd = 0;
    unit_tag = 0; unit_res = 0; unit_status = 0;

    // ---- reset state
    do_reset();
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_res", resp_res, 32'd0);
    chk("rst_resp_status", {24'd0, resp_status}, 32'd0);
    chk("rst_unit_en", {31'd0, unit_en}, 32'd0);
    chk("rst_unit_opa", unit_opa, 32'd0);
    chk("rst_unit_tag", {30'd0, unit_tag_o}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready_hi", {31'd0, req_ready}, 32'd1);
    unit_ready = 1'b0;
    #1;
    chk("rst_ready_lo", {31'd0, req_ready}, 32'd0);
    unit_ready = 1'b1;
    tick();

    // ---- out-of-order return, in-order response
    exp_res[0] = 32'hA000_0000; exp_res[1] = 32'hA111_1111; exp_res[2] = 32'hA222_2222;
    issue(32'h1111_0001, 2'd0);
    issue(32'h2222_0002, 2'd1);
    issue(32'h3333_0003, 2'd2);
    ret(2'd2, exp_res[2], 8'h22);
    chk("ooo_no_head_yet", {31'd0, resp_valid}, 32'd0);
    unit_valid = 1'b1; unit_tag = 2'd0; unit_res = exp_res[0]; unit_status = 8'h00;
    #1;
    chk("head_same_cycle", {31'd0, resp_valid}, {31'd0, BYP});
    tick();
    unit_valid = 1'b0;
    chk("head_next_cycle", {31'd0, resp_valid}, 32'd1);
    ret(2'd1, exp_res[1], 8'h11);
    for (int i = 0; i < 3; i++) begin
      chk("order_valid", {31'd0, resp_valid}, 32'd1);
      chk("order_res", resp_res, exp_res[i]);
      chk("order_status", {24'd0, resp_status}, {24'd0, exp_res[i][7:0] ^ exp_res[i][7:0]} | (i * 32'h11));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
    chk("order_drained", {31'd0, resp_valid}, 32'd0);
    chk("order_err", {31'd0, err}, 32'd0);

    // ---- full, then one retire re-enables next cycle
    do_reset();
    for (int i = 0; i < 4; i++) issue(32'h4000_0000 + i, 2'(i));
    req_valid = 1'b1; req_opa = 32'hDEAD_BEEF;
    #1;
    chk("full_ready", {31'd0, req_ready}, 32'd0);
    chk("full_en", {31'd0, unit_en}, 32'd0);
    chk("full_opa_zero", unit_opa, 32'd0);
    req_valid = 1'b0;
    tick();
    ret(2'd0, 32'h5000_0000, 8'h50);
    resp_ready = 1'b1; req_valid = 1'b1;
    #1;
    chk("full_retire_cycle_ready", {31'd0, req_ready}, 32'd0);
    chk("full_retire_res", resp_res, 32'h5000_0000);
    tick();
    resp_ready = 1'b0; req_valid = 1'b0;
    #1;
    chk("after_retire_ready", {31'd0, req_ready}, 32'd1);
    issue(32'h6000_0005, 2'd0);

    // ---- fire and retire together at count 2 leave count at 2
    do_reset();
    issue(32'h7000_0000, 2'd0);
    issue(32'h7000_0001, 2'd1);
    ret(2'd0, 32'h7777_0000, 8'h70);
    resp_ready = 1'b1;
    issue(32'h7000_0002, 2'd2);
    resp_ready = 1'b0;
    issue(32'h7000_0003, 2'd3);
    #1;
    chk("cnt2_not_full", {31'd0, req_ready}, 32'd1);
    tick();
    issue(32'h7000_0004, 2'd0);
    #1;
    chk("cnt2_full", {31'd0, req_ready}, 32'd0);
    tick();

    // ---- stray result: discarded, sticky error
    do_reset();
    issue(32'h8000_0000, 2'd0);
    ret(2'd3, 32'hBAD0_0003, 8'hBA);
    chk("stray_err", {31'd0, err}, 32'd1);
    chk("stray_discard", {31'd0, resp_valid}, 32'd0);
    tick(); tick();
    chk("stray_err_sticky", {31'd0, err}, 32'd1);
    ret(2'd0, 32'h8888_0000, 8'h88);
    chk("stray_good_res", resp_res, 32'h8888_0000);
    chk("stray_err_held", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("stray_err_cleared", {31'd0, err}, 32'd0);

    // ---- reset mid-operation
    do_reset();
    issue(32'h9000_0000, 2'd0);
    issue(32'h9000_0001, 2'd1);
    issue(32'h9000_0002, 2'd2);
    ret(2'd0, 32'h9999_0000, 8'h99);
    chk("mid_head_valid", {31'd0, resp_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_resp_res", resp_res, 32'd0);
    for (int i = 0; i < 4; i++) issue(32'h9100_0000 + i, 2'(i));
    #1;
    chk("mid_count_zero", {31'd0, req_ready}, 32'd0);
    tick();

    // ---- result in the first cycle after reset is an error
    do_reset();
    ret(2'd0, 32'hCAFE_0000, 8'hCA);
    chk("post_rst_err", {31'd0, err}, 32'd1);

    // ---- randomized traffic against an in-order model
    do_reset();
    q.delete();
    n_iss = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid  = 1'($urandom_range(0, 1));
      unit_ready = ($urandom_range(0, 3) != 0);
      resp_ready = 1'($urandom_range(0, 1));
      req_opa = $urandom; req_opb = $urandom;
      req_sub = 1'($urandom_range(0, 1)); req_rnd = 3'($urandom_range(0, 7));
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(i);
      pick = -1;
      unit_valid = 1'b0;
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = pend[$urandom_range(0, pend.size() - 1)];
        unit_valid = 1'b1; unit_tag = q[pick].tag;
        unit_res = q[pick].res; unit_status = q[pick].st;
      end
      #1;
      exp_ready = unit_ready && (q.size() < 4);
      exp_en    = req_valid && exp_ready;
      exp_rv    = (q.size() > 0) && (q[0].done || (BYP && pick == 0));
      chk("rnd_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("rnd_en", {31'd0, unit_en}, {31'd0, exp_en});
      if (exp_en) begin
        chk("rnd_tag", {30'd0, unit_tag_o}, {30'd0, n_iss[1:0]});
        chk("rnd_opb", unit_opb, req_opb);
      end else begin
        chk("rnd_opa_idle", unit_opa, 32'd0);
      end
      chk("rnd_resp_valid", {31'd0, resp_valid}, {31'd0, exp_rv});
      if (exp_rv) begin
        chk("rnd_resp_res", resp_res, q[0].res);
        chk("rnd_resp_status", {24'd0, resp_status}, {24'd0, q[0].st});
      end else begin
        chk("rnd_resp_res_idle", resp_res, 32'd0);
      end
      if (pick >= 0) q[pick].done = 1'b1;
      if (exp_rv && resp_ready) void'(q.pop_front());
      if (exp_en) begin
        q.push_back('{tag: n_iss[1:0],
                      res: req_sub ? req_opa - req_opb : req_opa + req_opb,
                      st: req_opa[7:0] ^ 8'h3c, done: 1'b0});
        n_iss++;
      end
      tick();
    end
    unit_valid = 1'b0; req_valid = 1'b0;
    #1;
    chk("rnd_err", {31'd0, err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_addsub_issuer.md
FP_ADDSUB_ISSUER -- requirements
Module: fp_addsub_issuer

Interface
REQ-001 The block SHALL have parameter TAG_WIDTH, default 2, giving the tag width; up to 2**TAG_WIDTH operations may be outstanding.
REQ-002 The block SHALL have parameter RND_WIDTH, default 3, giving the rounding-mode width.
REQ-003 The block SHALL have parameter STAT_WIDTH, default 8, giving the status-flag width; operand width SHALL be FP_WIDTH from apu_cluster_package.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  synchronous active-low reset.
REQ-007 req_valid_i / req_ready_o  in/out  1 each  core request handshake.
REQ-008 req_sub_i  input  1  1 = subtract, 0 = add.
REQ-009 req_opa_i, req_opb_i  input  FP_WIDTH each  operands; req_rnd_i  input  RND_WIDTH  rounding mode.
REQ-010 resp_valid_o / resp_ready_i  out/in  1 each  core response handshake.
REQ-011 resp_res_o  output  FP_WIDTH  result; resp_status_o  output  STAT_WIDTH  status flags.
REQ-012 unit_en_o, unit_subsel_o  output  1 each  unit enable and add/sub select.
REQ-013 unit_opa_o, unit_opb_o  output  FP_WIDTH each; unit_tag_o  output  TAG_WIDTH; unit_rnd_o  output  RND_WIDTH.
REQ-014 unit_ready_i  input  1  unit can accept an operation this cycle.
REQ-015 unit_valid_i  input  1; unit_tag_i  input  TAG_WIDTH; unit_res_i  input  FP_WIDTH; unit_status_i  input  STAT_WIDTH  returned result.
REQ-016 err_o  output  1  sticky protocol-error flag.

Function
REQ-017 Issue fire SHALL be req_valid_i && req_ready_o; req_ready_o = unit_ready_i && (count < 2**TAG_WIDTH).
REQ-018 unit_en_o SHALL equal issue fire, combinationally, same cycle.
REQ-019 unit_opa_o, unit_opb_o, unit_subsel_o, unit_rnd_o SHALL pass the request fields when unit_en_o=1 and be all-zero otherwise.
REQ-020 unit_tag_o SHALL equal the issue pointer wr_ptr; wr_ptr SHALL increment modulo 2**TAG_WIDTH on each fire.
REQ-021 A reorder buffer of 2**TAG_WIDTH entries (res, status, valid bit) SHALL be indexed by tag.
REQ-022 unit_valid_i=1 for an outstanding tag SHALL write res/status into that entry and set its valid bit at the next edge.
REQ-023 Tag outstanding means: within [rd_ptr, wr_ptr) modulo wrap, with count>0, and valid bit clear.
REQ-024 unit_valid_i=1 for a non-outstanding tag SHALL be discarded and SHALL set err_o, which holds until reset.
REQ-025 resp_valid_o SHALL equal the valid bit of entry rd_ptr; resp_res_o and resp_status_o SHALL show that entry when resp_valid_o=1 and zero otherwise.
REQ-026 Responses SHALL be returned in issue order regardless of unit return order.
REQ-027 resp_valid_o && resp_ready_i SHALL clear the head valid bit and increment rd_ptr modulo 2**TAG_WIDTH.
REQ-028 count (TAG_WIDTH+1 bits) SHALL increment on fire and decrement on retire; it SHALL be unchanged when both occur in the same cycle.
REQ-029 A same-cycle result write to one entry and retire of another SHALL both take effect.
REQ-030 Full (count=2**TAG_WIDTH) SHALL deassert req_ready_o; a retire in that cycle SHALL re-enable it next cycle, not the same cycle.
REQ-031 resp_valid_o SHALL hold, with stable data, until accepted.

Reset
REQ-032 With rst_ni=0 at a clock edge, wr_ptr, rd_ptr, count, all valid bits and err_o SHALL clear, including mid-operation.
REQ-033 Outputs after reset SHALL be: resp_valid_o=0, resp_res_o=0, resp_status_o=0, unit_* all zero, err_o=0; req_ready_o = unit_ready_i.
REQ-034 Unit results arriving in the first cycle after reset SHALL be flagged by err_o (REQ-024).

Configuration
REQ-035 Macro FP_ADDSUB_ISSUER_BYPASS_EN, when defined, SHALL present a unit result whose tag equals rd_ptr, with count>0, on resp_* combinationally in the same cycle.
REQ-036 Under that macro, if the bypassed result is accepted, it SHALL not be written and rd_ptr SHALL advance; otherwise it SHALL be written normally.
REQ-037 Without FP_ADDSUB_ISSUER_BYPASS_EN, the minimum latency from unit_valid_i to resp_valid_o SHALL be one cycle.

Verification
REQ-038 Issue tags 0,1,2; unit returns 2,0,1, each one cycle after the previous -> resp returns tag0,1,2 data in order; err_o=0.
REQ-039 Issue 4 ops without returns (TAG_WIDTH=2) -> req_ready_o=0 after 4th; one retire -> ready=1 next cycle, 5th op gets tag 0.
REQ-040 Same cycle: fire plus retire at count=2 -> count stays 2; unit_opa_o=0 whenever unit_en_o=0.
REQ-041 unit_valid_i with tag 3 when only tag 0 is outstanding -> result discarded, err_o=1 until rst_ni=0.
REQ-042 Reset asserted with 3 outstanding and 1 valid head -> next cycle resp_valid_o=0, count=0, next issue gets tag 0.
REQ-043 With macro defined: head result plus resp_ready_i=1 -> resp_valid_o=1 same cycle; without macro -> resp_valid_o=1 one cycle later.
